// File: rtl/riscv_mem_arbiter.sv
// Two-port (fetch/data) arbiter onto one pipelined memory port, with an in-order read tag pipe.
// Build option: define ARB_ROUND_ROBIN_EN for alternating arbitration; otherwise data wins with a starvation override.
module riscv_mem_arbiter #(
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        i_req_in,
    input  logic [31:0] i_addr_in,
    output logic        i_ready_out,
    output logic [31:0] i_rdata_out,
    output logic        i_rvalid_out,
    input  logic        d_req_in,
    input  logic [31:0] d_addr_in,
    input  logic [31:0] d_wdata_in,
    input  logic [2:0]  d_size_in,
    input  logic        d_we_in,
    output logic        d_ready_out,
    output logic [31:0] d_rdata_out,
    output logic        d_rvalid_out,
    output logic [31:0] mem_addr_out,
    output logic [31:0] mem_wdata_out,
    output logic [2:0]  mem_size_out,
    output logic        mem_we_out,
    output logic        mem_re_out,
    input  logic [31:0] mem_rdata_in
);

    localparam logic [2:0] SIZE_WORD = 3'b010;

    logic                    grant_i;
    logic                    grant_d;
    logic                    accept;
    logic                    accept_read;
    logic                    prefer_fetch;
    logic                    last_grant;
    logic [READ_LATENCY-1:0] tag_valid;
    logic [READ_LATENCY-1:0] tag_owner;
    logic                    rsp_valid;

`ifdef ARB_ROUND_ROBIN_EN
    // last_grant = 1 means data went last, so it is fetch's turn.
    assign prefer_fetch = last_grant;
`else
    logic [3:0] starve_cnt;

    // A non-zero count always follows a data grant, so last_grant is 1 whenever the limit is hit.
    assign prefer_fetch = last_grant && (starve_cnt == 4'(STARVE_LIMIT));

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            starve_cnt <= '0;
        end else if (grant_i || !i_req_in) begin
            starve_cnt <= '0;
        end else if (grant_d) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end
`endif

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!rst_in) begin
            if (i_req_in && d_req_in) begin
                grant_i = prefer_fetch;
                grant_d = !prefer_fetch;
            end else begin
                grant_i = i_req_in;
                grant_d = d_req_in;
            end
        end
    end

    assign i_ready_out = grant_i;
    assign d_ready_out = grant_d;
    assign accept      = grant_i || grant_d;
    assign accept_read = grant_i || (grant_d && !d_we_in);

    always_comb begin
        mem_addr_out  = '0;
        mem_wdata_out = '0;
        mem_size_out  = '0;
        mem_we_out    = 1'b0;
        mem_re_out    = 1'b0;
        if (grant_i) begin
            mem_addr_out = i_addr_in;
            mem_size_out = SIZE_WORD;
            mem_re_out   = 1'b1;
        end else if (grant_d) begin
            mem_addr_out  = d_addr_in;
            mem_wdata_out = d_wdata_in;
            mem_size_out  = d_size_in;
            mem_we_out    = d_we_in;
            mem_re_out    = !d_we_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tag_valid  <= '0;
            tag_owner  <= '0;
            last_grant <= 1'b1;
        end else begin
            tag_valid[0] <= accept_read;
            tag_owner[0] <= grant_d;
            for (int k = 1; k < READ_LATENCY; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_owner[k] <= tag_owner[k-1];
            end
            if (accept) begin
                last_grant <= grant_d;
            end
        end
    end

    // The oldest tag stage lines up with the cycle memory presents its read data.
    assign rsp_valid    = tag_valid[READ_LATENCY-1] && !rst_in;
    assign i_rvalid_out = rsp_valid && !tag_owner[READ_LATENCY-1];
    assign d_rvalid_out = rsp_valid && tag_owner[READ_LATENCY-1];
    assign i_rdata_out  = i_rvalid_out ? mem_rdata_in : '0;
    assign d_rdata_out  = d_rvalid_out ? mem_rdata_in : '0;

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 SHALL have parameter READ_LATENCY, default 2, cycles from read issue to mem_rdata_in valid (legal 1..4).
REQ-002 SHALL have parameter STARVE_LIMIT, default 4, max consecutive data grants while a fetch waits (legal 1..15).
REQ-003 SHALL have port clk_in  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port rst_in  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports i_req_in input 1 fetch request; i_addr_in input 32 fetch byte address; i_ready_out output 1 fetch accepted this cycle.
REQ-006 SHALL have ports i_rdata_out output 32 fetch data; i_rvalid_out output 1 fetch data valid.
REQ-007 SHALL have ports d_req_in input 1 data request; d_addr_in input 32 byte address; d_wdata_in input 32 store data; d_size_in input 3 access size code; d_we_in input 1 store (1) / load (0).
REQ-008 SHALL have ports d_ready_out output 1 data accepted this cycle; d_rdata_out output 32 load data; d_rvalid_out output 1 load data valid.
REQ-009 SHALL have ports mem_addr_out output 32; mem_wdata_out output 32; mem_size_out output 3; mem_we_out output 1; mem_re_out output 1; mem_rdata_in input 32 (shared memory-interface port).

Function
REQ-010 SHALL accept at most one request per cycle; a requester is accepted when req_in=1 and its ready_out=1 in the same cycle; ready_out is combinational from req_in and arbiter state.
REQ-011 SHALL drive the accepted request onto mem_* combinationally in the acceptance cycle: fetch -> mem_re_out=1, mem_size_out=word code, mem_wdata_out=0; data -> mem_we_out=d_we_in, mem_re_out=~d_we_in, size/wdata passed through.
REQ-012 SHALL drive mem_addr_out, mem_wdata_out, mem_size_out, mem_we_out, mem_re_out to 0 in cycles with no acceptance.
REQ-013 SHALL record each accepted read in a READ_LATENCY-deep tag shift register {valid, owner}; stores enter valid=0.
REQ-014 SHALL assert exactly one of i_rvalid_out/d_rvalid_out for one cycle exactly READ_LATENCY cycles after read acceptance, with the matching rdata_out = mem_rdata_in; both rdata outputs SHALL be 0 when their rvalid is 0.
REQ-015 SHALL never produce a response for a store.
REQ-016 SHALL sustain back-to-back accepts every cycle; responses return in issue order with no bubbles inserted.
REQ-017 SHALL, with only one requester asserting, grant it immediately.
REQ-018 SHALL, when both request in the same cycle, resolve per the arbitration policy (REQ-023/REQ-024); the loser's ready_out=0 and it SHALL hold its request fields stable until accepted.
REQ-019 SHALL keep a 4-bit starve counter: increments on each data grant while i_req_in=1 and fetch not granted; clears on any fetch grant or when i_req_in=0; when counter = STARVE_LIMIT, the next contended cycle SHALL grant fetch.
REQ-020 SHALL hold a 1-bit last_grant register (0=fetch, 1=data) updated on every acceptance.

Reset
REQ-021 SHALL, on rst_in=1 at a rising edge, clear tag register, starve counter, last_grant (to 1, data); during rst_in=1 all outputs SHALL be 0 and no request accepted.
REQ-022 SHALL discard reads in flight when reset is asserted mid-operation: no rvalid in any cycle after reset for reads issued before it, even if mem_rdata_in changes.

Configuration
REQ-023 With ARB_ROUND_ROBIN_EN defined, contention SHALL grant the requester opposite last_grant (alternating), and the starve counter SHALL be absent (REQ-019 not applicable).
REQ-024 Without ARB_ROUND_ROBIN_EN, contention SHALL grant data over fetch, subject to the REQ-019 starvation override.

Verification
REQ-025 Single fetch: i_req_in=1, i_addr_in=0x100 one cycle, mem returns 0xDEADBEEF at cycle+2 -> mem_re_out=1, mem_addr_out=0x100 at cycle 0; i_rvalid_out=1, i_rdata_out=0xDEADBEEF at cycle 2 only.
REQ-026 Contention, default build: both request continuously, d loads to 0x200.. -> 4 data grants, then 1 fetch grant, repeating; responses routed to correct port in order.
REQ-027 Contention, ARB_ROUND_ROBIN_EN: both request continuously after reset -> grants F,D,F,D...; no gaps on the memory port.
REQ-028 Store: d_req_in=1, d_we_in=1, d_addr_in=0x40, d_wdata_in=0x12345678 -> mem_we_out=1 one cycle with those values; no d_rvalid_out ever.
REQ-029 Reset mid-flight: load accepted, rst_in=1 next cycle for one cycle -> neither rvalid asserts in the following 4 cycles.
REQ-030 Back-to-back mixed: F@0x0, D-load@0x8, F@0x4 on consecutive cycles -> i_rvalid, d_rvalid, i_rvalid on cycles 2,3,4.
